// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin between the ALU and load sources onto one
// register-file write port, with a pending-register scoreboard for hazard queries.
module wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic        issue_ready,
  input  logic        ex_valid,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_data,
  output logic        ex_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  output logic        regwrite,
  output logic [4:0]  write_register,
  output logic [31:0] write_data,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic        rs1_busy,
  output logic        rs2_busy,
  input  logic        flush
);

  typedef enum logic {
    FAV_EX  = 1'b0,
    FAV_MEM = 1'b1
  } rr_e;

  rr_e         rr_ptr;
  logic [31:0] pending;
  logic [31:0] pending_next;
  logic        accept;
  logic        issue_fire;
  logic [4:0]  sel_rd;
  logic [31:0] sel_data;

  // The pointer only matters when both sources contend.
  assign ex_ready  = ex_valid  && (!mem_valid || rr_ptr == FAV_EX);
  assign mem_ready = mem_valid && (!ex_valid  || rr_ptr == FAV_MEM);
  assign accept    = ex_ready || mem_ready;
  assign sel_rd    = mem_ready ? mem_rd   : ex_rd;
  assign sel_data  = mem_ready ? mem_data : ex_data;

  // pending[0] is forced low, so x0 is never busy and never stalls issue.
  assign issue_ready = !pending[issue_rd];
  assign issue_fire  = issue_valid && issue_ready && (issue_rd != 5'd0);
  assign rs1_busy    = pending[rs1_addr];
  assign rs2_busy    = pending[rs2_addr];

  always_comb begin
    // NOTE: every path starts from a full default, so no latch can be inferred.
    pending_next = pending;
    if (regwrite) pending_next[write_register] = 1'b0;
    // Set is applied after clear so a same-cycle reissue keeps the bit.
    if (issue_fire) pending_next[issue_rd] = 1'b1;
    if (flush) pending_next = '0;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the scoreboard is a flop vector, not RAM, so it is reset with the rest.
      regwrite       <= 1'b0;
      write_register <= 5'd0;
      write_data     <= 32'd0;
      pending        <= '0;
      rr_ptr         <= FAV_EX;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      pending  <= pending_next;
      regwrite <= accept && (sel_rd != 5'd0);
      if (accept) begin
        write_register <= sel_rd;
        write_data     <= sel_data;
        rr_ptr         <= mem_ready ? FAV_EX : FAV_MEM;
      end
    end
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have the issue-side ports issue_valid (in, 1), issue_rd (in, 5) and issue_ready (out, 1): the issuing instruction reserves its destination register.
REQ-004 The block SHALL have the ALU writeback-source ports ex_valid (in, 1), ex_rd (in, 5), ex_data (in, 32) and ex_ready (out, 1).
REQ-005 The block SHALL have the load writeback-source ports mem_valid (in, 1), mem_rd (in, 5), mem_data (in, 32) and mem_ready (out, 1).
REQ-006 The block SHALL have the register-file write-port outputs regwrite (out, 1), write_register (out, 5) and write_data (out, 32).
REQ-007 The block SHALL have the hazard-query ports rs1_addr (in, 5), rs2_addr (in, 5), rs1_busy (out, 1) and rs2_busy (out, 1).
REQ-008 The block SHALL have the port flush (in, 1): it clears all reservations.

Function
REQ-009 A source transfer SHALL occur on a rising edge where valid and ready are both 1.
REQ-010 At most one source SHALL be accepted per cycle.
REQ-011 ex_ready and mem_ready SHALL be combinational from the valids and the round-robin pointer.
REQ-012 Arbitration SHALL be as follows:
- only one source valid: that source gets ready=1;
- both valid: the grant goes to the source not granted most recently (1-bit pointer, reset value = favour ex);
- the pointer SHALL update only on an accepted transfer.
REQ-013 Registered output with a latency of one cycle SHALL apply: a transfer accepted in cycle N drives regwrite=1, write_register and write_data in cycle N+1 only.
REQ-014 When no transfer is accepted, regwrite SHALL be 0 in the next cycle; write_register and write_data hold their previous values.
REQ-015 A transfer with rd=0 SHALL be accepted normally (ready follows arbitration); regwrite stays 0 and the scoreboard is unchanged.
REQ-016 The scoreboard SHALL be a 32-bit pending vector:
- bit 0 is hard-wired to 0;
- bit rd sets on an issue handshake with rd≠0;
- bit write_register clears at the end of a cycle with regwrite=1.
REQ-017 issue_ready SHALL equal !pending[issue_rd] (WAW stall); issue_rd=0 always gives issue_ready=1.
REQ-018 If a set and a clear of the same bit fall in the same cycle, the set SHALL win.
REQ-019 rsX_busy SHALL equal pending[rsX_addr], combinational; an address of 0 gives 0.
REQ-020 A register SHALL be reported busy through its acceptance cycle and its regwrite cycle, and not busy from the following cycle on.
REQ-021 flush=1 SHALL clear the pending vector at the edge and block any issue set in that cycle.
REQ-022 flush SHALL NOT cancel an output write already registered, and source transfers continue unaffected.
REQ-023 Writeback for a non-pending rd (post-flush) SHALL still write the register file and SHALL NOT change the scoreboard.

Reset
REQ-024 While rst=1 the block SHALL hold: regwrite=0, write_register=0, write_data=0, pending=0, round-robin pointer=ex.
REQ-025 Assertion of rst mid-operation SHALL discard any registered write immediately (regwrite drops asynchronously).
REQ-026 The first transfer SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-027 The bench SHALL cover single source: ex_valid=1, ex_rd=5, ex_data=0x1234 for 1 cycle -> next cycle regwrite=1, write_register=5, write_data=0x1234; following cycle regwrite=0.
REQ-028 The bench SHALL cover contention: ex and mem both valid for 4 cycles (rd 3 / rd 4) -> grants ex, mem, ex, mem; regwrite each cycle after the first.
REQ-029 The bench SHALL cover the scoreboard: issue rd=7; rs1_addr=7 -> rs1_busy=1; ex writeback rd=7 -> busy until the end of the regwrite cycle, then 0; a second issue rd=7 gets issue_ready=0 until clear.
REQ-030 The bench SHALL cover set/clear collision: regwrite to rd=9 in the same cycle as an issue handshake of rd=9 -> pending[9]=1 afterwards.
REQ-031 The bench SHALL cover x0 and flush:
- ex_rd=0 -> ex_ready=1 and regwrite stays 0;
- flush with pending {2,6} -> rs busy for both = 0 next cycle, while an in-flight write still appears.
REQ-032 The bench SHALL cover reset mid-write: rst asserted during a cycle with regwrite=1 -> regwrite=0 without waiting for a clock edge, and all outputs at reset values.
